// File: rtl/cdc_handshake_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_rx
// Description : Receive side of a 4-phase req/ack clock-domain crossing.
//               The sender's request level is synchronized into outClk.
//               The payload is captured once on the synchronized request and
//               presented on a valid/ready interface. The acknowledge is
//               raised after the local consumer takes the word.
//
//   Ports
//     outClk     in   local clock, rising edge
//     rst        in   synchronous active-high reset
//     reqAsync   in   4-phase request level from the sender domain
//     dataAsync  in   sender payload, stable from req rise to ack rise
//     ackAsync   out  4-phase acknowledge level to the sender (flop output)
//     outValid   out  outData holds an undelivered word
//     outReady   in   local consumer ready
//     outData    out  captured payload, registered
//     protoErr   out  one-cycle pulse when req falls before it was acked
//
// Revision    : 1.0  initial release
// ============================================================================
module cdc_handshake_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             outClk,
    input  logic             rst,
    input  logic             reqAsync,
    input  logic [WIDTH-1:0] dataAsync,
    output logic             ackAsync,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic             protoErr
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_HOLD    = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;

    logic [SYNC_STAGES-1:0] r_reqSync;
    logic                   w_reqSync;
    logic                   r_reqSyncPrev;
    logic [1:0]             r_state;
    logic [1:0]             w_nextState;
    logic                   r_ack;
    logic                   w_nextAck;
    logic                   r_valid;
    logic                   w_nextValid;
    logic [WIDTH-1:0]       r_data;
    logic                   w_capture;
    logic                   r_protoErr;
    logic                   w_protoErr;

    // Only the last synchronizer stage is ever looked at by the control logic.
    assign w_reqSync = r_reqSync[SYNC_STAGES-1];

    always_ff @(posedge outClk) begin
        if (rst) begin
            r_reqSync     <= '0;
            r_reqSyncPrev <= 1'b0;
        end else begin
            r_reqSync     <= {r_reqSync[SYNC_STAGES-2:0], reqAsync};
            r_reqSyncPrev <= w_reqSync;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextValid = r_valid;
        w_nextAck   = r_ack;
        w_capture   = 1'b0;
        w_protoErr  = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_nextValid = 1'b0;
                w_nextAck   = 1'b0;
                if (w_reqSync) begin
                    // dataAsync has been stable for at least SYNC_STAGES
                    // cycles by now, so a plain register capture is safe.
                    w_capture   = 1'b1;
                    w_nextValid = 1'b1;
                    w_nextState = c_HOLD;
                end
            end
            c_HOLD: begin
                w_nextValid = 1'b1;
                w_nextAck   = 1'b0;
                // Req withdrawn before ack: flag it once, but still deliver
                // the word and run the ack phase so the sender can recover.
                if (r_reqSyncPrev && !w_reqSync) begin
                    w_protoErr = 1'b1;
                end
                if (outReady) begin
                    w_nextValid = 1'b0;
                    w_nextAck   = 1'b1;
                    w_nextState = c_RELEASE;
                end
            end
            c_RELEASE: begin
                // Stay here while req is still high so the same request is
                // never captured twice.
                w_nextValid = 1'b0;
                w_nextAck   = 1'b1;
                if (!w_reqSync) begin
                    w_nextAck   = 1'b0;
                    w_nextState = c_IDLE;
                end
            end
            default: begin
                w_nextState = c_IDLE;
                w_nextValid = 1'b0;
                w_nextAck   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge outClk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_valid    <= 1'b0;
            r_ack      <= 1'b0;
            r_data     <= '0;
            r_protoErr <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_valid    <= w_nextValid;
            r_ack      <= w_nextAck;
            r_protoErr <= w_protoErr;
            if (w_capture) begin
                r_data <= dataAsync;
            end
        end
    end

    assign ackAsync = r_ack;
    assign outValid = r_valid;
    assign outData  = r_data;
    assign protoErr = r_protoErr;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cdc_handshake_rx
// Description : Directed bench for cdc_handshake_rx with default parameters
//               (WIDTH=32, SYNC_STAGES=2). Edge numbers in comments count
//               outClk rising edges from the first edge sampling a new req
//               level.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cdc_handshake_rx;

    logic        outClk;
    logic        rst;
    logic        reqAsync;
    logic [31:0] dataAsync;
    logic        ackAsync;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic        protoErr;

    int total = 0;
    int bad   = 0;

    cdc_handshake_rx #(
        .WIDTH       (32),
        .SYNC_STAGES (2)
    ) dut (
        .outClk    (outClk),
        .rst       (rst),
        .reqAsync  (reqAsync),
        .dataAsync (dataAsync),
        .ackAsync  (ackAsync),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData),
        .protoErr  (protoErr)
    );

    initial outClk = 1'b0;
    always #5 outClk = ~outClk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge outClk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; reqAsync = 1'b0; dataAsync = 32'hFFFF_FFFF; outReady = 1'b0;
        tick(); tick();
        total++; if (ackAsync !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ackAsync); end
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", outValid); end
        total++; if (outData !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=00000000", outData); end
        total++; if (protoErr !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", protoErr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        outReady = 1'b1; dataAsync = 32'hDEAD_BEEF; reqAsync = 1'b1;
        tick(); tick(); // edges 1,2
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL lat_early_valid got=%b exp=0", outValid); end
        tick(); // edge 3
        total++; if (outValid !== 1'b1 || outData !== 32'hDEAD_BEEF)
            begin bad++; $display("FAIL lat_capture valid=%b data=%h exp valid=1 data=deadbeef", outValid, outData); end
        total++; if (ackAsync !== 1'b0) begin bad++; $display("FAIL lat_ack_early got=%b exp=0", ackAsync); end
        tick(); // edge 4: transfer
        total++; if (outValid !== 1'b0 || ackAsync !== 1'b1)
            begin bad++; $display("FAIL lat_transfer valid=%b ack=%b exp valid=0 ack=1", outValid, ackAsync); end
        reqAsync = 1'b0;
        tick(); tick(); // low edges 1,2
        total++; if (ackAsync !== 1'b1) begin bad++; $display("FAIL lat_ack_hold got=%b exp=1", ackAsync); end
        tick(); // low edge 3
        total++; if (ackAsync !== 1'b0) begin bad++; $display("FAIL lat_ack_fall got=%b exp=0", ackAsync); end
        total++; if (outData !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lat_data_retain got=%h exp=deadbeef", outData); end
    endtask

    task automatic test_stall();
        int badCycles;
        badCycles = 0;
        outReady = 1'b0; dataAsync = 32'h1234_5678; reqAsync = 1'b1;
        tick(); tick(); tick();
        total++; if (outValid !== 1'b1) begin bad++; $display("FAIL stall_valid_rise got=%b exp=1", outValid); end
        dataAsync = 32'h0BAD_0BAD; // sender may not do this, but the held word must not follow
        for (int i = 0; i < 10; i++) begin
            tick();
            if (outValid !== 1'b1 || outData !== 32'h1234_5678 || ackAsync !== 1'b0) badCycles++;
        end
        total++; if (badCycles !== 0) begin bad++; $display("FAIL stall_hold bad_cycles=%0d exp=0", badCycles); end
        outReady = 1'b1;
        tick();
        total++; if (outValid !== 1'b0 || ackAsync !== 1'b1)
            begin bad++; $display("FAIL stall_release valid=%b ack=%b exp valid=0 ack=1", outValid, ackAsync); end
        reqAsync = 1'b0;
        tick(); tick(); tick();
        total++; if (ackAsync !== 1'b0) begin bad++; $display("FAIL stall_ack_fall got=%b exp=0", ackAsync); end
        total++; if (outData !== 32'h1234_5678) begin bad++; $display("FAIL stall_retain got=%h exp=12345678", outData); end
    endtask

    task automatic test_hold_req();
        int validSeen;
        int ackLow;
        validSeen = 0; ackLow = 0;
        outReady = 1'b1; dataAsync = 32'hA5A5_5A5A; reqAsync = 1'b1;
        tick(); tick(); tick(); tick(); // capture on 3, transfer on 4
        total++; if (ackAsync !== 1'b1) begin bad++; $display("FAIL holdreq_ack got=%b exp=1", ackAsync); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (outValid !== 1'b0) validSeen++;
            if (ackAsync !== 1'b1) ackLow++;
        end
        total++; if (validSeen !== 0) begin bad++; $display("FAIL holdreq_recapture valid_cycles=%0d exp=0", validSeen); end
        total++; if (ackLow !== 0) begin bad++; $display("FAIL holdreq_ack_drop low_cycles=%0d exp=0", ackLow); end
        reqAsync = 1'b0;
        tick(); tick(); tick();
        total++; if (ackAsync !== 1'b0) begin bad++; $display("FAIL holdreq_ack_fall got=%b exp=0", ackAsync); end
    endtask

    task automatic test_proto_err();
        outReady = 1'b0; dataAsync = 32'hCAFE_F00D; reqAsync = 1'b1;
        tick(); tick(); tick();
        total++; if (outValid !== 1'b1) begin bad++; $display("FAIL perr_valid got=%b exp=1", outValid); end
        reqAsync = 1'b0;
        tick(); tick(); // reqSync reaches 0 after low edge 2
        total++; if (protoErr !== 1'b0) begin bad++; $display("FAIL perr_early got=%b exp=0", protoErr); end
        tick(); // low edge 3 sees the fall
        total++; if (protoErr !== 1'b1) begin bad++; $display("FAIL perr_pulse got=%b exp=1", protoErr); end
        tick();
        total++; if (protoErr !== 1'b0) begin bad++; $display("FAIL perr_width got=%b exp=0", protoErr); end
        total++; if (outValid !== 1'b1 || outData !== 32'hCAFE_F00D)
            begin bad++; $display("FAIL perr_word_kept valid=%b data=%h exp valid=1 data=cafef00d", outValid, outData); end
        outReady = 1'b1;
        tick();
        total++; if (ackAsync !== 1'b1 || outValid !== 1'b0)
            begin bad++; $display("FAIL perr_ack_rise ack=%b valid=%b exp ack=1 valid=0", ackAsync, outValid); end
        tick(); // req already low: ack high for exactly one cycle
        total++; if (ackAsync !== 1'b0) begin bad++; $display("FAIL perr_ack_fall got=%b exp=0", ackAsync); end
        tick();
    endtask

    task automatic test_reset_mid();
        // Reset while in HOLD
        outReady = 1'b0; dataAsync = 32'h1111_1111; reqAsync = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        total++; if (outValid !== 1'b0 || ackAsync !== 1'b0 || outData !== 32'h0 || protoErr !== 1'b0)
            begin bad++; $display("FAIL rsthold_clear valid=%b ack=%b data=%h err=%b exp all 0", outValid, ackAsync, outData, protoErr); end
        rst = 1'b0;
        tick(); tick();
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL rsthold_early got=%b exp=0", outValid); end
        tick();
        total++; if (outValid !== 1'b1 || outData !== 32'h1111_1111)
            begin bad++; $display("FAIL rsthold_recapture valid=%b data=%h exp valid=1 data=11111111", outValid, outData); end
        // Reset while in RELEASE
        outReady = 1'b1;
        tick();
        total++; if (ackAsync !== 1'b1) begin bad++; $display("FAIL rstrel_ack got=%b exp=1", ackAsync); end
        rst = 1'b1;
        tick();
        total++; if (outValid !== 1'b0 || ackAsync !== 1'b0 || outData !== 32'h0 || protoErr !== 1'b0)
            begin bad++; $display("FAIL rstrel_clear valid=%b ack=%b data=%h err=%b exp all 0", outValid, ackAsync, outData, protoErr); end
        dataAsync = 32'h2222_2222;
        rst = 1'b0;
        tick(); tick();
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL rstrel_early got=%b exp=0", outValid); end
        tick();
        total++; if (outValid !== 1'b1 || outData !== 32'h2222_2222)
            begin bad++; $display("FAIL rstrel_recapture valid=%b data=%h exp valid=1 data=22222222", outValid, outData); end
        tick();
        reqAsync = 1'b0;
        tick(); tick(); tick();
        total++; if (ackAsync !== 1'b0) begin bad++; $display("FAIL rstrel_ack_fall got=%b exp=0", ackAsync); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sent[$];
        logic [31:0] got[$];
        logic [31:0] w;
        real         sPer;
        int          n;
        int          errSeen;
        bit          timedOut;
        bit          done;
        bit          rdy;
        errSeen = 0; timedOut = 1'b0; done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100 && !timedOut; i++) begin
                    // Sender period 3.7..29 ns against a 10 ns outClk.
                    sPer = $urandom_range(37, 290) / 10.0;
                    w = $urandom;
                    sent.push_back(w);
                    dataAsync = w;
                    #(sPer);
                    reqAsync = 1'b1;
                    n = 0;
                    while (ackAsync !== 1'b1 && n < 300) begin #(sPer); n++; end
                    if (n >= 300) timedOut = 1'b1;
                    reqAsync = 1'b0;
                    n = 0;
                    while (ackAsync !== 1'b0 && n < 300) begin #(sPer); n++; end
                    if (n >= 300) timedOut = 1'b1;
                    #(sPer);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge outClk);
                    if (protoErr === 1'b1) errSeen++;
                    rdy = 1'($urandom_range(0, 1));
                    // outValid/outData are stable until the next rising edge,
                    // which is the edge that will see this ready value.
                    if (outValid === 1'b1 && rdy) got.push_back(outData);
                    outReady = rdy;
                end
            end
        join
        outReady = 1'b0;
        total++; if (timedOut) begin bad++; $display("FAIL b2b_timeout got=1 exp=0"); end
        total++; if (got.size() != sent.size())
            begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got.size(), sent.size()); end
        for (int i = 0; i < got.size() && i < sent.size(); i++) begin
            total++;
            if (got[i] !== sent[i]) begin bad++; $display("FAIL b2b_word idx=%0d got=%h exp=%h", i, got[i], sent[i]); end
        end
        total++; if (errSeen !== 0) begin bad++; $display("FAIL b2b_protoerr cycles=%0d exp=0", errSeen); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_hold_req();
        test_proto_err();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdc_handshake_rx.md
CDC_HANDSHAKE_RX -- requirements
Module: cdc_handshake_rx

Interface
REQ-001 Parameter WIDTH, default 32: data bus width in bits, legal range 1..256.
REQ-002 Parameter SYNC_STAGES, default 2: req synchronizer depth, legal range 2..4.
REQ-003 outClk  input  1  single clock; all block flops are clocked on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 reqAsync  input  1  4-phase request level from the sender domain, asynchronous to outClk.
REQ-006 dataAsync  input  WIDTH  sender payload, held stable by the sender from req rise until ack rise.
REQ-007 ackAsync  output  1  4-phase acknowledge level to the sender; driven directly from a flop.
REQ-008 outValid  output  1  local valid: outData holds an undelivered word.
REQ-009 outReady  input  1  local consumer ready.
REQ-010 outData  output  WIDTH  captured payload, registered.
REQ-011 protoErr  output  1  one-cycle pulse on a sender protocol violation.

Function
REQ-012 reqAsync SHALL pass through a chain of SYNC_STAGES flops (reqSync) before any use; dataAsync SHALL be sampled only on the capture edge and is never synchronized bitwise.
REQ-013 FSM states SHALL be IDLE, HOLD and RELEASE, with IDLE as the reset state.
REQ-014 IDLE: ackAsync=0 and outValid=0; when reqSync=1, on that edge capture dataAsync into outData, set outValid=1 and go to HOLD.
REQ-015 Latency: the first outClk edge sampling reqAsync=1 is edge 1; outValid and outData SHALL update on edge SYNC_STAGES+1.
REQ-016 HOLD: outValid=1 and outData is stable; an edge with outValid=1 and outReady=1 is a transfer; on that edge clear outValid, set ackAsync=1 and go to RELEASE.
REQ-017 If outReady=1 when outValid rises, the transfer SHALL occur on the next edge, giving exactly one cycle of outValid.
REQ-018 RELEASE: ackAsync=1; when reqSync=0, on that edge clear ackAsync and go to IDLE.
REQ-019 Ack fall latency: ackAsync SHALL fall on edge SYNC_STAGES+1, counted from the first edge sampling reqAsync=0.
REQ-020 A new request SHALL be accepted only from IDLE; a req that is still high in RELEASE SHALL NOT be captured twice.
REQ-021 reqSync falling while in HOLD is a protocol violation: pulse protocErr for one cycle on the edge that sees the fall; the held word SHALL still be delivered and the ack issued.
REQ-022 If req is low when RELEASE is entered, the transition to IDLE SHALL follow one cycle later, so ackAsync is high for at least one cycle.
REQ-023 After a transfer, outData SHALL retain its last value until the next capture.
REQ-024 Throughput: at most one word per full 4-phase cycle; outValid never asserts while ackAsync=1.

Reset
REQ-025 While rst=1 at an edge, all of the following SHALL be cleared: the state (to IDLE), every reqSync stage, ackAsync, outValid, outData and protoErr (all 0).
REQ-026 Reset mid-transaction SHALL drop the held word without delivering it; if reqAsync is still high after reset release, it SHALL be treated as a new request after full synchronizer latency.
REQ-027 No output SHALL be X after the first reset edge.

Verification
REQ-028 SYNC_STAGES=2, outReady=1, req rises with data 0xDEADBEEF: outValid=1 with outData=0xDEADBEEF on edge 3 for one cycle; ackAsync=1 on edge 4; req dropped, so ackAsync=0 three edges after req is first sampled low.
REQ-029 outReady=0 for 10 cycles after outValid rises: outValid and outData are held stable and ackAsync stays 0; outReady=1 transfers the word on the next edge, and ack follows on that edge.
REQ-030 Sender holds req high for 20 cycles after ack: exactly one transfer occurs, ack stays 1, and no second outValid appears.
REQ-031 Req drops while in HOLD: protoErr pulses for 1 cycle, the word is still delivered, ack rises and then falls, and the state returns to IDLE.
REQ-032 rst=1 asserted in HOLD and in RELEASE: the next edge shows all outputs at 0; req held high through reset produces a fresh capture at edge SYNC_STAGES+1 after release.
REQ-033 Back-to-back: 100 random words at random outReady, with an asynchronous sender clock ratio of 0.37..2.9: every word is delivered in order with no duplicates or drops, and protoErr is never asserted.
